// File: rtl/fsk_demodulator.sv
// fsk_demodulator
//   Binary FSK demodulator for an 8-bit full-wave-rectified ADC stream.
//   A hysteresis comparator finds the rising edge of each rectified hump.
//   The clock count between consecutive edges classifies the hump as mark
//   (short period, bit 1) or space (long period, bit 0). A debounce filter
//   then updates the output bit.
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous reset, active-high
//   ad_data      unsigned rectified ADC sample, one per clock
//   demod_bit    registered demodulated bit
//   demod_valid  one-cycle strobe, a hump was classified
module fsk_demodulator #(
  parameter logic [7:0]  HI_TH      = 8'd160,
  parameter logic [7:0]  LO_TH      = 8'd96,
  parameter int unsigned PERIOD_TH  = 18,
  parameter int unsigned MAX_PERIOD = 255,
  parameter int unsigned DEBOUNCE   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ad_data,
  output logic       demod_bit,
  output logic       demod_valid
);

  localparam int unsigned AW = $clog2(DEBOUNCE + 1);
  localparam logic [7:0]    PTH  = 8'(PERIOD_TH);
  localparam logic [7:0]    MAXP = 8'(MAX_PERIOD);
  localparam logic [AW-1:0] DEB  = AW'(DEBOUNCE);

  // ARM: the next edge only starts the period timer (after reset or
  // carrier loss). RUN: every edge is classified.
  typedef enum logic {ARM, RUN} arm_e;

  arm_e          arm_q, arm_d;
  logic [7:0]    ad_q, ad_d;
  logic          comp_q, comp_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] agree_q, agree_d;
  logic          last_q, last_d;
  logic          bit_q, bit_d;
  logic          valid_q, valid_d;

  logic          hump_edge;
  logic          cls;
  logic [AW-1:0] agree_nx;

  always_comb begin
    ad_d = ad_data;

    hump_edge = (ad_q >= HI_TH) && !comp_q;

    comp_d = comp_q;
    if (ad_q >= HI_TH) begin
      comp_d = 1'b1;
    end else if (ad_q <= LO_TH) begin
      comp_d = 1'b0;
    end

    if (hump_edge) begin
      cnt_d = 8'd1;
    end else if (cnt_q >= MAXP) begin
      cnt_d = MAXP;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    cls = (cnt_q < PTH);
    if (cls == last_q) begin
      agree_nx = (agree_q >= DEB) ? DEB : agree_q + AW'(1);
    end else begin
      agree_nx = AW'(1);
    end
  end

  always_comb begin
    arm_d   = arm_q;
    agree_d = agree_q;
    last_d  = last_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    unique case (arm_q)
      ARM: begin
        if (hump_edge) begin
          arm_d = RUN;
        end
      end
      RUN: begin
        // An edge in the saturation cycle wins over the timeout.
        if (hump_edge) begin
          valid_d = 1'b1;
          agree_d = agree_nx;
          last_d  = cls;
          if (agree_nx == DEB) begin
            bit_d = cls;
          end
        end else if (cnt_q >= MAXP) begin
          arm_d   = ARM;
          agree_d = '0;
        end
      end
      default: arm_d = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q   <= ARM;
      ad_q    <= '0;
      comp_q  <= 1'b0;
      cnt_q   <= '0;
      agree_q <= '0;
      last_q  <= 1'b0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      arm_q   <= arm_d;
      ad_q    <= ad_d;
      comp_q  <= comp_d;
      cnt_q   <= cnt_d;
      agree_q <= agree_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
    end
  end

  assign demod_bit   = bit_q;
  assign demod_valid = valid_q;

endmodule

// File: tb/tb_fsk_demodulator.sv
// tb_fsk_demodulator
//   Directed and randomized hump sequences for fsk_demodulator. A reference
//   model works on absolute sample times: it finds hump rises with a
//   hysteresis rule and classifies each from the elapsed time since the
//   previous rise. Outputs are compared every cycle, plus spot checks of
//   demod_bit at the points of interest.
module tb_fsk_demodulator;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ad_data;
  logic       demod_bit;
  logic       demod_valid;

  int checks   = 0;
  int failures = 0;

  fsk_demodulator #(
    .HI_TH(8'd160), .LO_TH(8'd96), .PERIOD_TH(18), .MAX_PERIOD(255), .DEBOUNCE(2)
  ) dut (
    .clk(clk), .rst(rst), .ad_data(ad_data),
    .demod_bit(demod_bit), .demod_valid(demod_valid)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         now;         // index of the sample being evaluated
  int         last_rise;   // time of previous rise (or of reset)
  bit         m_high;      // hysteresis comparator level
  bit         m_first;     // next rise only starts timing
  bit         m_last;
  int         m_agree;
  bit         m_bit;
  logic [7:0] prev;        // sample the pipeline register holds

  task automatic model_reset();
    m_high    = 1'b0;
    m_first   = 1'b1;
    m_last    = 1'b0;
    m_agree   = 0;
    m_bit     = 1'b0;
    last_rise = now;
  endtask

  task automatic model_eval(input logic [7:0] s, output bit ev, output bit eb);
    int gap;
    bit rise;
    bit c;
    gap  = now - last_rise;
    rise = (s >= 8'd160) && !m_high;
    if (s >= 8'd160) m_high = 1'b1;
    else if (s <= 8'd96) m_high = 1'b0;
    ev = 1'b0;
    if (rise) begin
      // More than 255 clocks without a rise means the carrier was lost.
      if (gap > 255) begin
        m_first = 1'b1;
        m_agree = 0;
      end
      if (m_first) begin
        m_first = 1'b0;
      end else begin
        c  = (gap < 18);
        ev = 1'b1;
        if (c == m_last) m_agree = (m_agree + 1 > 2) ? 2 : m_agree + 1;
        else m_agree = 1;
        m_last = c;
        if (m_agree == 2) m_bit = c;
      end
      last_rise = now;
    end
    eb  = m_bit;
    now = now + 1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  // One clock: drive sample/reset, then compare outputs after the edge.
  task automatic step(input logic [7:0] v, input bit r);
    bit ev, eb;
    rst     = r;
    ad_data = v;
    if (r) begin
      model_reset();
      prev = '0;
      ev   = 1'b0;
      eb   = 1'b0;
    end else begin
      model_eval(prev, ev, eb);
      prev = v;
    end
    @(posedge clk);
    #1;
    check("demod_valid", demod_valid, ev);
    check("demod_bit", demod_bit, eb);
  endtask

  // One hump of period p: high half then low half.
  task automatic hump(input int p, input bit noisy);
    int h;
    logic [7:0] v;
    h = p / 2;
    for (int i = 0; i < p; i++) begin
      if (i < h) begin
        if (noisy && i > 0 && $urandom_range(3) == 0) v = 8'($urandom_range(159, 97));
        else v = noisy ? 8'($urandom_range(255, 160)) : 8'd255;
      end else begin
        if (noisy && i > h && $urandom_range(3) == 0) v = 8'($urandom_range(159, 97));
        else v = noisy ? 8'($urandom_range(96, 0)) : 8'd0;
      end
      step(v, 1'b0);
    end
  endtask

  task automatic humps(input int p, input int n, input bit noisy);
    for (int k = 0; k < n; k++) hump(p, noisy);
  endtask

  initial begin
    int p;
    now     = 0;
    prev    = '0;
    rst     = 1'b1;
    ad_data = 8'd200;
    model_reset();

    // Reset held with a high input
    for (int i = 0; i < 5; i++) step(8'd200, 1'b1);

    // Mark run, period 12
    humps(12, 8, 1'b0);
    check("mark_run_bit", demod_bit, 1'b1);

    // Space run, period 25: falls after two space humps
    humps(25, 3, 1'b0);
    check("space_run_bit", demod_bit, 1'b0);
    humps(12, 4, 1'b0);
    check("mark_again_bit", demod_bit, 1'b1);
    hump(25, 1'b0);
    humps(12, 3, 1'b0);
    check("single_space_bit", demod_bit, 1'b1);

    // Between thresholds only: no edges
    for (int i = 0; i < 200; i++) step(8'($urandom_range(150, 100)), 1'b0);
    check("hyst_hold_bit", demod_bit, 1'b1);

    // Carrier loss, then debounce restarts from scratch
    for (int i = 0; i < 300; i++) step(8'd0, 1'b0);
    check("timeout_hold_bit", demod_bit, 1'b1);
    humps(25, 2, 1'b0);
    check("rearm_one_space_bit", demod_bit, 1'b1);
    hump(25, 1'b0);
    check("rearm_two_space_bit", demod_bit, 1'b0);

    // Period boundary 17/18
    humps(17, 4, 1'b0);
    check("period17_bit", demod_bit, 1'b1);
    humps(18, 3, 1'b0);
    check("period18_bit", demod_bit, 1'b0);

    // Saturation boundary: 255 classified, 256 times out
    hump(255, 1'b0);
    hump(12, 1'b0);
    hump(256, 1'b0);
    humps(12, 4, 1'b0);
    check("post_sat_bit", demod_bit, 1'b1);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) step(8'd255, 1'b0);
    step(8'd0, 1'b1);
    humps(12, 2, 1'b0);
    check("post_rst_two_bit", demod_bit, 1'b0);
    hump(12, 1'b0);
    check("post_rst_three_bit", demod_bit, 1'b1);

    // Randomized noisy humps with occasional carrier loss and resets
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(9) == 0) p = int'($urandom_range(300, 250));
      else p = int'($urandom_range(40, 8));
      hump(p, 1'b1);
      if ($urandom_range(19) == 0) step(8'($urandom), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
